// File: rtl/dac_if.sv
// Sample/serial bundle between the stereo DAC controller and its neighbours.
// master = controller side, slave = sample source / DAC side.
interface dac_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        next;
  logic        mclk;
  logic        sclk;
  logic        lrck;
  logic        sdti;

  modport master (
    input  sample_l, sample_r,
    output next, mclk, sclk, lrck, sdti
  );

  modport slave (
    output sample_l, sample_r,
    input  next, mclk, sclk, lrck, sdti
  );
endinterface

// File: rtl/dac_controller.sv
// Left-justified 16-bit stereo DAC driver: one 10-bit frame counter derives
// mclk/sclk/lrck, and a registered sdti presents each bit for one full sclk period.
module dac_controller (
  input  logic  clk,
  input  logic  reset,
  dac_if.master bus
);

  logic [9:0]  cnt_reg;
  logic [9:0]  cnt_next;
  logic [15:0] latch_l_reg, latch_l_next;
  logic [15:0] latch_r_reg, latch_r_next;
  logic [15:0] word_next;
  logic        next_reg;
  logic        sdti_reg, sdti_next;
  logic        capture;

  // sdti is computed for the upcoming count so it lands in a register exactly
  // when the counter reaches that bit; the capture edge bypasses the latches.
  always_comb begin
    capture      = (cnt_reg == 10'd1023);
    cnt_next     = cnt_reg + 10'd1;
    latch_l_next = capture ? bus.sample_l : latch_l_reg;
    latch_r_next = capture ? bus.sample_r : latch_r_reg;
    word_next    = cnt_next[9] ? latch_r_next : latch_l_next;
    sdti_next    = cnt_next[8] ? 1'b0 : word_next[~cnt_next[7:4]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      latch_l_reg <= '0;
      latch_r_reg <= '0;
      next_reg    <= 1'b0;
      sdti_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      latch_l_reg <= latch_l_next;
      latch_r_reg <= latch_r_next;
      next_reg    <= capture;
      sdti_reg    <= sdti_next;
    end
  end

  assign bus.mclk = cnt_reg[1];
  assign bus.sclk = cnt_reg[3];
  assign bus.lrck = ~cnt_reg[9];
  assign bus.next = next_reg;
  assign bus.sdti = sdti_reg;

endmodule

// File: tb/tb_dac_controller.sv
// Scoreboard bench for dac_controller: stimulus queues expected sdti bits per
// frame, a monitor pops one at every sclk rising edge and checks clock outputs.
module tb_dac_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dac_if bus ();

  dac_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc;
  bit sb[$];

  logic [15:0] tbl_l [4] = '{16'h0FF0, 16'h8001, 16'hFFFF, 16'h1234};
  logic [15:0] tbl_r [4] = '{16'hAA55, 16'h7FFE, 16'h0000, 16'hABCD};

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    for (int i = 15; i >= 0; i--) sb.push_back(l[i]);
    for (int i = 0; i < 16; i++) sb.push_back(1'b0);
    for (int i = 15; i >= 0; i--) sb.push_back(r[i]);
    for (int i = 0; i < 16; i++) sb.push_back(1'b0);
    $display("queued frame: left=%04h right=%04h", l, r);
  endtask

  task automatic wait_next();
    bit got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(negedge clk);
      if (bus.next) got = 1'b1;
    end
    chk("next_timeout", int'(got), 1);
  endtask

  // Posedges since the last reset release equal the DUT frame position.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: clock outputs every cycle, sdti at each sclk rising edge.
  initial begin
    logic       prev_sclk;
    logic [9:0] c;
    logic [3:0] exp_vec;
    bit         exp_bit;
    prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sclk = 1'b0;
      end else begin
        c = cyc[9:0];
        exp_vec = {c == 10'd0, c[1], c[3], ~c[9]};
        chk("next_mclk_sclk_lrck", int'({bus.next, bus.mclk, bus.sclk, bus.lrck}), int'(exp_vec));
        if (bus.sclk && !prev_sclk) begin
          if (sb.size() == 0) begin
            chk("sdti_queue_empty", 0, 1);
          end else begin
            exp_bit = sb.pop_front();
            chk("sdti", int'(bus.sdti), int'(exp_bit));
          end
        end
        prev_sclk = bus.sclk;
      end
    end
  end

  initial begin
    bus.sample_l = tbl_l[0];
    bus.sample_r = tbl_r[0];
    push_frame(16'h0000, 16'h0000);
    push_frame(tbl_l[0], tbl_r[0]);
    #100;
    chk("reset_outputs", int'({bus.next, bus.mclk, bus.sclk, bus.lrck, bus.sdti}), 5'b00010);
    #45 reset = 1'b0;

    // Change samples one clk after each next; the running frame keeps the old pair.
    for (int k = 1; k < 4; k++) begin
      wait_next();
      @(posedge clk);
      #1;
      bus.sample_l = tbl_l[k];
      bus.sample_r = tbl_r[k];
      push_frame(tbl_l[k], tbl_r[k]);
    end

    // Mid-frame reset during right-channel shifting.
    wait_next();
    repeat (700) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midframe_reset_outputs", int'({bus.next, bus.mclk, bus.sclk, bus.lrck, bus.sdti}), 5'b00010);
    sb.delete();
    push_frame(16'h0000, 16'h0000);
    push_frame(tbl_l[3], tbl_r[3]);
    #40 reset = 1'b0;

    wait_next();
    wait_next();
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
